// File: rtl/fetch_unit.sv
// Instruction-fetch stage: architectural PC, deferred PC commits while a fetch
// is outstanding, req/ack instruction-memory handshake with a timeout, and IR.
// Optional feature macro: FETCH_UNIT_EPC_EN (exception PC capture register).
module fetch_unit #(
   parameter logic [31:2] RESET_PC = 30'h0000_0C00,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:2] npc,
   input  logic        pc_wr,
   input  logic        fetch_start,
   output logic [31:2] pc,
   output logic        imem_req,
   output logic [31:2] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic        busy,
   output logic        fetch_err,
   input  logic        exc,
   output logic [31:2] epc
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             start_c;
   logic             ack_exit_c;
   logic             to_exit_c;
   logic             exit_c;
   logic             pc_apply_c;
   logic             pend_apply_c;
   logic [CNT_W-1:0] cnt_q;
   logic [31:2]      pend_pc_q;
   logic             pend_valid_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and fetch-event decode
   always_comb begin
      state_d    = state_q;
      start_c    = 1'b0;
      ack_exit_c = 1'b0;
      to_exit_c  = 1'b0;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (fetch_start) begin
               start_c = 1'b1;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (imem_ack) begin
               ack_exit_c = 1'b1;
               state_d    = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               to_exit_c = 1'b1;
               state_d   = S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // PC commit decode: direct write when not busy or on exit, else replay pending
   always_comb begin
      exit_c       = ack_exit_c | to_exit_c;
      pc_apply_c   = pc_wr & ((state_q != S_BUSY) | exit_c);
      pend_apply_c = exit_c & ~pc_wr & pend_valid_q;
   end

   // PC, deferred-PC buffer, fetch request and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         pend_pc_q    <= '0;
         pend_valid_q <= 1'b0;
         imem_req     <= 1'b0;
         imem_addr    <= RESET_PC;
         cnt_q        <= '0;
         busy         <= 1'b0;
         fetch_err    <= 1'b0;
      end else begin
         busy <= (state_d == S_BUSY);

         if (pc_apply_c)        pc <= npc;
         else if (pend_apply_c) pc <= pend_pc_q;

         if (exit_c) begin
            pend_valid_q <= 1'b0;
         end else if ((state_q == S_BUSY) && pc_wr) begin
            pend_pc_q    <= npc;
            pend_valid_q <= 1'b1;
         end

         if (start_c) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_wr ? npc : pc;
            cnt_q     <= '0;
            fetch_err <= 1'b0;
         end else if (state_q == S_BUSY) begin
            if (exit_c) imem_req <= 1'b0;
            else        cnt_q    <= cnt_q + CNT_W'(1);
            if (to_exit_c) fetch_err <= 1'b1;
         end
      end
   end

   // Instruction register; ir only counts as valid if pc did not move under it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir       <= '0;
         ir_valid <= 1'b0;
      end else begin
         if (ack_exit_c) ir <= imem_rdata;
         if (start_c || pc_apply_c || pend_apply_c) ir_valid <= 1'b0;
         else if (ack_exit_c)                       ir_valid <= 1'b1;
      end
   end

`ifdef FETCH_UNIT_EPC_EN
   // Exception PC: captures pc as it was before any same-edge update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   epc <= '0;
      else if (exc) epc <= pc;
   end
`else
   logic unused_exc;
   assign unused_exc = exc;
   assign epc        = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps followed by random traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

   localparam int          TO  = 4;
   localparam logic [31:2] RPC = 30'h0000_0C00;

   logic        clk;
   logic        rst_n;
   logic [31:2] npc;
   logic        pc_wr;
   logic        fetch_start;
   logic [31:2] pc;
   logic        imem_req;
   logic [31:2] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        busy;
   logic        fetch_err;
   logic        exc;
   logic [31:2] epc;

   fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .npc(npc), .pc_wr(pc_wr),
      .fetch_start(fetch_start), .pc(pc), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err),
      .exc(exc), .epc(epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:2] m_pc, m_addr, m_epc;
   logic [31:0] m_ir;
   logic        m_req, m_irv, m_busy, m_err;
   int          m_held;
   logic [31:2] m_pend[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc",        32'(pc),        32'(m_pc));
      chk("imem_req",  32'(imem_req),  32'(m_req));
      chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("ir",        ir,             m_ir);
      chk("ir_valid",  32'(ir_valid),  32'(m_irv));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("epc",       32'(epc),       32'(m_epc));
   endtask

   task automatic model_reset();
      m_pc = RPC; m_addr = RPC; m_epc = '0; m_ir = '0;
      m_req = 1'b0; m_irv = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      m_held = 0;
      m_pend.delete();
   endtask

   // One clock edge of the fetch stage, from the current input values
   task automatic model_edge();
      logic [31:2] old_pc;
      bit          changed;
      old_pc = m_pc;
`ifdef FETCH_UNIT_EPC_EN
      if (exc) m_epc = old_pc;
`endif
      if (!m_busy) begin
         if (pc_wr) begin
            m_pc  = npc;
            m_irv = 1'b0;
         end
         if (fetch_start) begin
            m_busy = 1'b1; m_req = 1'b1; m_err = 1'b0; m_irv = 1'b0;
            m_addr = pc_wr ? npc : old_pc;
            m_held = 0;
         end
      end else begin
         m_held++;
         if (imem_ack || m_held == TO) begin
            changed = pc_wr || (m_pend.size() > 0);
            if (pc_wr)                  m_pc = npc;
            else if (m_pend.size() > 0) m_pc = m_pend[$];
            if (imem_ack) begin
               m_ir  = imem_rdata;
               m_irv = !changed;
            end else begin
               m_err = 1'b1;
            end
            m_busy = 1'b0; m_req = 1'b0;
            m_pend.delete();
         end else if (pc_wr) begin
            m_pend.push_back(npc);
         end
      end
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass, check
   task automatic step(input logic [31:2] n, input logic w, input logic fs,
                       input logic a, input logic [31:0] rd, input logic x);
      npc = n; pc_wr = w; fetch_start = fs; imem_ack = a; imem_rdata = rd; exc = x;
      @(posedge clk);
      model_edge();
      #1 check_all();
      @(negedge clk);
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock
   task automatic do_reset();
      npc = '0; pc_wr = 1'b0; fetch_start = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; exc = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      npc = '0; pc_wr = 1'b0; fetch_start = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; exc = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Basic fetch: request next cycle, ack on the third cycle
      step('0, 0, 1, 0, '0, 0);
      step('0, 0, 0, 0, '0, 0);
      step('0, 0, 0, 1, 32'h2408_0001, 0);
      step('0, 0, 0, 0, '0, 0);

      // Timeout after exactly TO request cycles, then retry from ERR
      step('0, 0, 1, 0, '0, 0);
      for (int i = 0; i < TO; i++) step('0, 0, 0, 0, '0, 0);
      step('0, 0, 0, 1, 32'hDEAD_BEEF, 0);   // ack outside BUSY is ignored
      step('0, 0, 1, 0, '0, 0);
      step('0, 0, 0, 1, 32'h1111_2222, 0);

      // Deferred PC writes while busy; latest wins, ir stays invalid
      step('0, 0, 1, 0, '0, 0);
      step(30'h0000_0C05, 1, 0, 0, '0, 0);
      step(30'h0000_0C09, 1, 1, 0, '0, 0);   // fetch_start in BUSY ignored
      step('0, 0, 0, 1, 32'h3333_4444, 0);
      step('0, 0, 0, 0, '0, 0);

      // PC write and fetch_start together in IDLE
      step(30'h0000_0C10, 1, 1, 0, '0, 0);
      step('0, 0, 0, 1, 32'h5555_6666, 0);

      // Exception captures the pre-update pc
      step(30'h0000_0C03, 1, 0, 0, '0, 0);
      step(30'h0000_1060, 1, 0, 0, '0, 1);
      step('0, 0, 0, 0, '0, 0);

      // Pending write overridden by a write on the exiting timeout edge
      step('0, 0, 1, 0, '0, 0);
      step(30'h0000_0AAA, 1, 0, 0, '0, 0);
      for (int i = 0; i < TO - 2; i++) step('0, 0, 0, 0, '0, 0);
      step(30'h0000_0BBB, 1, 0, 0, '0, 0);

      // Reset in the middle of a fetch
      step('0, 0, 1, 0, '0, 0);
      step('0, 0, 0, 0, '0, 0);
      do_reset();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(99) < 2) begin
            do_reset();
         end else begin
            step(30'($urandom), ($urandom_range(9) < 3), ($urandom_range(9) < 4),
                 ($urandom_range(9) < 3), $urandom, ($urandom_range(9) < 2));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly downstream of the next-PC logic: holds the architectural PC register, commits the next-PC value on request, and fetches the instruction word at PC from instruction memory over a req/ack handshake. The fetched word is latched into the instruction register (IR). PC is fed back to next-PC as its current-PC input. An optional EPC register captures the faulting PC on exceptions.

## Interface

Parameters:
- RESET_PC, 30'h0000_0C00, word address loaded into PC on reset (byte address 0x0000_3000).
- TIMEOUT, 15, maximum cycles a fetch request is held without ack; legal range 1..255.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc  in  [31:2]  next PC from next-PC stage.
- pc_wr  in  1  commit npc into PC.
- fetch_start  in  1  single-cycle request to fetch the instruction at PC.
- pc  out  [31:2]  current PC, to next-PC stage.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  [31:2]  fetch word address, registered, stable while imem_req=1.
- imem_ack  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  [31:0]  instruction word, valid when imem_ack=1.
- ir  out  [31:0]  instruction register.
- ir_valid  out  1  ir holds the word for current pc.
- busy  out  1  state is BUSY.
- fetch_err  out  1  last fetch timed out.
- exc  in  1  exception event; capture pc into EPC.
- epc  out  [31:2]  exception PC.

## Operation

- States: IDLE, BUSY, ERR.
- IDLE: fetch_start -> BUSY; imem_req<=1; imem_addr <= pc_wr ? npc : pc; timeout counter <= 0.
- BUSY, imem_ack=1: ir<=imem_rdata, ir_valid<=1, imem_req<=0 -> IDLE.
- BUSY, no ack: counter increments; when counter==TIMEOUT-1 and no ack -> ERR, imem_req<=0, fetch_err<=1. The request is held exactly TIMEOUT cycles.
- ERR: fetch_start -> BUSY (retry, same rules as IDLE), fetch_err<=0. Other inputs as in IDLE.
- fetch_start in BUSY: ignored. imem_ack outside BUSY: ignored.
- PC update: in IDLE/ERR, pc_wr -> pc<=npc same edge.
- In BUSY, pc_wr is deferred: pend_pc<=npc, pend_valid<=1; latest write wins. On BUSY exit (ack or timeout), pc<=pend_pc if pend_valid, then pend_valid<=0.
- pc_wr in the same cycle as the exiting ack/timeout: that npc is applied and overrides pend_pc.
- ir_valid<=0 on any effective PC change and on fetch_start accepted. An ack exit with a pending PC update sets ir but leaves ir_valid=0, because ir belongs to the old pc.
- exc=1: epc<=pc (value before any same-edge pc update).
- Arithmetic: PC is word-addressed [31:2]; no increment inside this block. Counter width is 8 bits.

## Timing

- Reset (async, any state, including mid-fetch) sets:
  - pc=RESET_PC, imem_addr=RESET_PC, epc=0.
  - imem_req=0, ir=0, ir_valid=0, busy=0, fetch_err=0.
  - State IDLE, pend_valid=0, counter=0.
- imem_req rises the cycle after fetch_start is sampled.
- Earliest ir_valid: 2 cycles after fetch_start (ack in first request cycle).
- busy equals (state==BUSY), registered.
- pc visible one cycle after the pc_wr edge; deferred update is visible the cycle after BUSY exit.

## Configuration

- FETCH_UNIT_EPC_EN defined: EPC register present, behaves as above.
- Not defined: no EPC register, exc is ignored, and epc is a constant 0. All other behaviour is unchanged.

## Test plan

- Reset, then fetch_start -> imem_req=1 at cycle+1, imem_addr=0xC00. Ack at cycle+3 with rdata=0x2408_0001 -> ir=0x2408_0001, ir_valid=1, busy=0.
- TIMEOUT=4, no ack -> imem_req high exactly 4 cycles, then fetch_err=1, state ERR. fetch_start -> fetch_err=0 and a new request goes out.
- pc_wr npc=0xC05 during BUSY, then npc=0xC09 in the next BUSY cycle, then ack -> pc=0xC09 after exit and ir_valid=0.
- pc_wr npc=0xC10 and fetch_start in the same IDLE cycle -> imem_addr=0xC10, pc=0xC10.
- With FETCH_UNIT_EPC_EN defined, pc=0xC03, exc=1 with pc_wr npc=0x1060 -> epc=0xC03, pc=0x1060. Without the macro -> epc=0.
- rst_n low mid-BUSY -> imem_req drops immediately and all outputs take their reset values.
